// File: rtl/mac_row_ctrl.sv
// ---------------------------------------------------------------------------
// mac_row_ctrl
//
// West-edge sequencer for one row of mac_tile instances. It takes a single
// valid/ready word stream and turns each job into four phases of row drive:
//   LOAD  : kernel words are shifted in with inst_w = 2'b01
//   GAP   : col quiet cycles so the last weight can reach the far tile
//   EXEC  : activation words are driven with inst_w = 2'b10
//   DRAIN : col quiet cycles so the last partial sums leave the row
// It then pulses done for one cycle. The row mode (4-bit or 2-bit weights) is
// latched at start and held on mode_o until the next accepted start.
//
// Parameters
//   bw     : width of weight/activation words
//   col    : tiles in the row (load count, gap length, drain length)
//   len_bw : width of the activation-count field
//
// Ports
//   clk        in   : rising-edge clock
//   reset      in   : synchronous, active-low clear of all state
//   start      in   : job request, honoured only in IDLE
//   mode       in   : 0 = 4-bit (col load words), 1 = 2-bit (2*col load words)
//   num_act    in   : activation words in the execute phase
//   data_in    in   : stream word
//   data_valid in   : data_in is valid
//   data_ready out  : word accepted this cycle (LOAD and EXEC only)
//   inst_w     out  : registered row instruction, bit0 = load, bit1 = execute
//   out_w      out  : registered word to the row's in_w
//   mode_o     out  : latched row mode
//   busy       out  : job in progress
//   done       out  : one-cycle end-of-job pulse
// ---------------------------------------------------------------------------
module mac_row_ctrl #(
    parameter int bw     = 4,
    parameter int col    = 8,
    parameter int len_bw = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [len_bw-1:0] num_act,
    input  logic [bw-1:0]     data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic [1:0]        inst_w,
    output logic [bw-1:0]     out_w,
    output logic              mode_o,
    output logic              busy,
    output logic              done
);

    // The transfer counter has to reach both the 2-bit load count and the
    // largest activation count the num_act field can express.
    localparam int ACT_MAX  = (32'sd1 <<< len_bw) - 32'sd1;
    localparam int LOAD_MAX = 32'sd2 * col;
    localparam int XFER_MAX = (LOAD_MAX > ACT_MAX) ? LOAD_MAX : ACT_MAX;
    localparam int XFER_W   = $clog2(XFER_MAX + 32'sd1);
    localparam int CYC_W    = $clog2(col + 32'sd1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_GAP   = 3'd2,
        S_EXEC  = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    state_e              state_q;
    logic                mode_q;
    logic [len_bw-1:0]   num_act_q;
    logic [XFER_W-1:0]   xfer_cnt_q;
    logic [CYC_W-1:0]    cyc_cnt_q;
    logic [1:0]          inst_w_q;
    logic [bw-1:0]       out_w_q;
    logic                busy_q;
    logic                done_q;

    logic                data_ready_s;
    logic                xfer_s;
    logic [XFER_W-1:0]   xfer_cnt_inc_s;
    logic [XFER_W-1:0]   load_target_s;
    logic                load_last_s;
    logic                exec_last_s;
    logic                cyc_last_s;

    // Handshake and phase-completion decodes.
    always_comb begin
        data_ready_s   = (state_q == S_LOAD) || (state_q == S_EXEC);
        xfer_s         = data_ready_s && data_valid;
        xfer_cnt_inc_s = xfer_cnt_q + XFER_W'(1);
        if (mode_q) begin
            load_target_s = XFER_W'(LOAD_MAX);
        end else begin
            load_target_s = XFER_W'(col);
        end
        // Compare against count+1 so the transition fires on the N-th transfer.
        load_last_s = (xfer_cnt_inc_s == load_target_s);
        exec_last_s = (xfer_cnt_inc_s == XFER_W'(num_act_q));
        cyc_last_s  = (cyc_cnt_q == CYC_W'(col - 32'sd1));
    end

    // Job sequencer: phase state, counters and all registered row outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            mode_q     <= 1'b0;
            num_act_q  <= {len_bw{1'b0}};
            xfer_cnt_q <= {XFER_W{1'b0}};
            cyc_cnt_q  <= {CYC_W{1'b0}};
            inst_w_q   <= 2'b00;
            out_w_q    <= {bw{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // Instruction and done are single-cycle unless a branch sets them.
            inst_w_q <= 2'b00;
            done_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mode_q     <= mode;
                        num_act_q  <= num_act;
                        busy_q     <= 1'b1;
                        xfer_cnt_q <= {XFER_W{1'b0}};
                        cyc_cnt_q  <= {CYC_W{1'b0}};
                        state_q    <= S_LOAD;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    if (xfer_s) begin
                        inst_w_q <= 2'b01;
                        out_w_q  <= data_in;
                        if (load_last_s) begin
                            xfer_cnt_q <= {XFER_W{1'b0}};
                            cyc_cnt_q  <= {CYC_W{1'b0}};
                            state_q    <= S_GAP;
                        end else begin
                            xfer_cnt_q <= xfer_cnt_inc_s;
                        end
                    end else begin
                        state_q <= S_LOAD;
                    end
                end
                S_GAP: begin
                    if (cyc_last_s) begin
                        xfer_cnt_q <= {XFER_W{1'b0}};
                        cyc_cnt_q  <= {CYC_W{1'b0}};
                        // An empty execute phase skips straight to the drain.
                        if (num_act_q != {len_bw{1'b0}}) begin
                            state_q <= S_EXEC;
                        end else begin
                            state_q <= S_DRAIN;
                        end
                    end else begin
                        cyc_cnt_q <= cyc_cnt_q + CYC_W'(1);
                    end
                end
                S_EXEC: begin
                    if (xfer_s) begin
                        inst_w_q <= 2'b10;
                        out_w_q  <= data_in;
                        if (exec_last_s) begin
                            xfer_cnt_q <= {XFER_W{1'b0}};
                            cyc_cnt_q  <= {CYC_W{1'b0}};
                            state_q    <= S_DRAIN;
                        end else begin
                            xfer_cnt_q <= xfer_cnt_inc_s;
                        end
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_DRAIN: begin
                    if (cyc_last_s) begin
                        xfer_cnt_q <= {XFER_W{1'b0}};
                        cyc_cnt_q  <= {CYC_W{1'b0}};
                        done_q     <= 1'b1;
                        state_q    <= S_DONE;
                    end else begin
                        cyc_cnt_q <= cyc_cnt_q + CYC_W'(1);
                    end
                end
                S_DONE: begin
                    // busy drops together with the return to IDLE.
                    xfer_cnt_q <= {XFER_W{1'b0}};
                    cyc_cnt_q  <= {CYC_W{1'b0}};
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: begin
                    xfer_cnt_q <= {XFER_W{1'b0}};
                    cyc_cnt_q  <= {CYC_W{1'b0}};
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign data_ready = data_ready_s;
    assign inst_w     = inst_w_q;
    assign out_w      = out_w_q;
    assign mode_o     = mode_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: doc/mac_row_ctrl.md
# mac_row_ctrl

Sequencer for the west edge of one row of `mac_tile` instances. It accepts a single valid/ready word stream and turns it into the row's `inst_w`/`in_w` drive. Each job is a kernel-load phase, a propagation gap, an execute phase and a drain. It sizes the load phase for 4-bit mode (one weight word per tile) or 2-bit mode (two weight words per tile) and holds the row mode stable for the whole job.

## Interface
- `bw`, 4, word width of weights and activations driven to the row.
- `col`, 8, number of tiles in the row; sets load count, gap length and drain length.
- `len_bw`, 8, width of the activation-count field.
- `clk` input 1: the block's only clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-low; 0 on a rising edge clears all state.
- `start` input 1: job request; sampled only in IDLE.
- `mode` input 1: 0 = 4-bit (one load word per tile), 1 = 2-bit (two load words per tile); sampled with `start`.
- `num_act` input `len_bw`: number of activation words in the execute phase; sampled with `start`.
- `data_in` input `bw`: stream word (weights during LOAD, activations during EXEC).
- `data_valid` input 1: `data_in` is valid.
- `data_ready` output 1: the block accepts a word this cycle.
- `inst_w` output 2: row instruction; bit0 = load, bit1 = execute.
- `out_w` output `bw`: word to the row's `in_w`.
- `mode_o` output 1: latched mode to every tile in the row.
- `busy` output 1: a job is in progress.
- `done` output 1: one-cycle end-of-job pulse.

## Operation
- States: IDLE, LOAD, GAP, EXEC, DRAIN, DONE.
- IDLE
  - `start`=1 latches `mode` into `mode_o` and `num_act` into an internal register, then goes to LOAD.
  - `start` in any other state is ignored.
- LOAD: load target N = `col` if mode 0, 2*`col` if mode 1.
  - Transfer = `data_valid` & `data_ready`.
  - Each transfer registers `inst_w`=2'b01 and `out_w`=`data_in`.
  - A cycle without a transfer registers `inst_w`=2'b00; `out_w` holds its previous value.
  - After the N-th transfer, go to GAP.
- GAP: exactly `col` cycles with `inst_w`=00 and `data_ready`=0, then EXEC. If the latched count is 0, go to DRAIN instead.
- EXEC: each transfer registers `inst_w`=2'b10 and `out_w`=`data_in`; a bubble registers `inst_w`=00. After `num_act` transfers, go to DRAIN.
- DRAIN: exactly `col` cycles with `inst_w`=00, then DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `data_ready` is combinational: 1 only in LOAD and EXEC.
- Counters
  - The transfer counter is wide enough for max(2*`col`, 2^`len_bw`-1).
  - The cycle counter is wide enough for `col`.
  - Both clear on every state entry.
- `mode_o` is constant from LOAD entry through DONE and keeps its value in IDLE.
- Reset (`reset`=0 on an edge), from any state including mid-LOAD or mid-EXEC: next state IDLE.
  - All outputs go to reset values: `inst_w`=00, `out_w`=0, `mode_o`=0, `busy`=0, `done`=0, `data_ready`=0.
  - Partially loaded tiles are not cleaned up by this block; the array is reset alongside.

## Timing
- `start` high at edge t in IDLE: state is LOAD from t+1, and `data_ready`=1 in that cycle.
- Transfer at edge u: `inst_w`/`out_w` carry the word from u+1, a one-cycle registered latency.
- Last LOAD transfer at edge u: GAP spans u+1 .. u+`col`, and EXEC begins at u+`col`+1.
- Last EXEC transfer at edge v: DRAIN spans v+1 .. v+`col`, DONE is at v+`col`+1, and IDLE follows at v+`col`+2.
- With zero bubbles, job length in cycles from the `start` edge to `done` = N + `col` + `num_act` + `col` + 1.
- `busy` = (state != IDLE); it is high the cycle after `start` and low the cycle after `done`.
- A new `start` is accepted in the same cycle as the IDLE state that follows DONE; no turnaround cycle beyond that.

## Test plan
- Mode 0, `col`=8, `num_act`=4, `data_valid` always 1, weights 1..8, acts 9..12 -> `inst_w`=01 for 8 consecutive cycles with `out_w`=1..8, then 8 cycles of 00, then 10 ×4 with `out_w`=9..12, then 8 idle cycles; `done` arrives 29 cycles after the `start` edge; `mode_o`=0.
- Mode 1, `col`=8, `num_act`=2 -> exactly 16 load transfers with `inst_w`=01; `mode_o`=1 throughout; `done` at 35 cycles after `start`.
- Mode 0 with `data_valid` toggling 1,0,1,0 in LOAD and EXEC -> `inst_w`=00 on the bubble cycles; `out_w` sequence is unchanged; transfer counts stay 8 and `num_act`.
- `num_act`=0 -> no `inst_w`=10 cycle ever; GAP goes straight to DRAIN; `done` at N+2·`col`+1 after `start`.
- `start` pulsed during LOAD and during DRAIN with different `mode`/`num_act` -> ignored; the job and `mode_o` are unchanged; the next `start` after `done` is accepted.
- `reset`=0 for one edge in the middle of EXEC -> the next cycle shows IDLE, `inst_w`=00, `out_w`=0, `busy`=0, `data_ready`=0, `mode_o`=0; a fresh job then completes with the nominal cycle count.
